// File: rtl/akuma_ai_keygen.sv
// CPU opponent for Akuma: picks approach/retreat/jump/crouch/idle once per frame
// and drives the four keycode slots the Akuma movement block expects.
module akuma_ai_keygen #(
   parameter int          NEAR_DIST     = 140,
   parameter int          FAR_DIST      = 300,
   parameter int          DECIDE_PERIOD = 16,
   parameter int          JUMP_HOLD     = 2,
   parameter int          CROUCH_FRAMES = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          BOUND_X_MAX   = 635
) (
   input  logic               frame_clk,
   input  logic               Reset,
   input  logic               enable,
   input  logic signed [31:0] XDist,
   input  logic [9:0]         AkumaX,
   input  logic               hit_taken,
   output logic [7:0]         keycode_0,
   output logic [7:0]         keycode_1,
   output logic [7:0]         keycode_2,
   output logic [7:0]         keycode_3,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      APPROACH = 3'd1,
      RETREAT  = 3'd2,
      JUMP     = 3'd3,
      CROUCH   = 3'd4
   } state_t;

   localparam logic [7:0]  KEY_LEFT       = 8'h0d;
   localparam logic [7:0]  KEY_RIGHT      = 8'h0f;
   localparam logic [7:0]  KEY_JUMP       = 8'h0c;
   localparam logic [7:0]  KEY_CROUCH     = 8'h0e;
   localparam logic [7:0]  RELOAD_DECIDE  = 8'(DECIDE_PERIOD - 1);
   localparam logic [7:0]  RELOAD_JUMP    = 8'(JUMP_HOLD - 1);
   localparam logic [7:0]  RELOAD_CROUCH  = 8'(CROUCH_FRAMES - 1);
   localparam logic [10:0] RETREAT_MARGIN = 11'd125;
   localparam logic [10:0] RETREAT_LIMIT  = 11'(BOUND_X_MAX);
   localparam logic [15:0] LFSR_MASK      = 16'hB400;

   state_t      state_reg, state_next, decide_state;
   logic [7:0]  timer_reg, timer_next;
   logic [15:0] lfsr_reg, lfsr_next;
   logic [1:0]  rnd;
   logic        close_range, long_range, at_right_bound;

   assign rnd            = lfsr_reg[1:0];
   assign lfsr_next      = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
   assign close_range    = (XDist <= NEAR_DIST);
   assign long_range     = (XDist >= FAR_DIST);
   // Retreating this close to the right edge would just pin Akuma against the wall.
   assign at_right_bound = (({1'b0, AkumaX} + RETREAT_MARGIN) >= RETREAT_LIMIT);

   function automatic logic [7:0] reload_for(input state_t s);
      case (s)
         JUMP:    reload_for = RELOAD_JUMP;
         CROUCH:  reload_for = RELOAD_CROUCH;
         default: reload_for = RELOAD_DECIDE;
      endcase
   endfunction

   always_comb begin
      decide_state = IDLE;
      if (close_range) begin
         case (rnd)
            2'd0:    decide_state = RETREAT;
            2'd1:    decide_state = JUMP;
            2'd2:    decide_state = CROUCH;
            default: decide_state = IDLE;
         endcase
      end else if (long_range) begin
         decide_state = (rnd == 2'd3) ? JUMP : APPROACH;
      end else begin
         case (rnd)
            2'd0:    decide_state = APPROACH;
            2'd1:    decide_state = RETREAT;
            2'd2:    decide_state = IDLE;
            default: decide_state = JUMP;
         endcase
      end
      if (decide_state == RETREAT && at_right_bound)
         decide_state = IDLE;
   end

   // Priority: disable, hit (unless airborne), running hold, jump landing, fresh decision.
   always_comb begin
      state_next = state_reg;
      timer_next = timer_reg;
      if (!enable) begin
         state_next = IDLE;
         timer_next = 8'd0;
      end else if (hit_taken && state_reg != JUMP) begin
         state_next = CROUCH;
         timer_next = RELOAD_CROUCH;
      end else if (timer_reg != 8'd0) begin
         timer_next = timer_reg - 8'd1;
      end else if (state_reg == JUMP) begin
         state_next = IDLE;
         timer_next = RELOAD_DECIDE;
      end else begin
         state_next = decide_state;
         timer_next = reload_for(decide_state);
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_reg <= IDLE;
         timer_reg <= 8'd0;
         lfsr_reg  <= LFSR_SEED;
         keycode_0 <= 8'h00;
         keycode_1 <= 8'h00;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         lfsr_reg  <= lfsr_next;
         keycode_0 <= (state_next == APPROACH) ? KEY_LEFT :
                      (state_next == RETREAT)  ? KEY_RIGHT : 8'h00;
         keycode_1 <= (state_next == JUMP)     ? KEY_JUMP :
                      (state_next == CROUCH)   ? KEY_CROUCH : 8'h00;
      end
   end

   assign keycode_2 = 8'h00;
   assign keycode_3 = 8'h00;
   assign state_dbg = state_reg;

endmodule

// File: tb/tb_akuma_ai_keygen.sv
// Directed bench for akuma_ai_keygen: four instances with different LFSR seeds,
// expected outputs queued as stimulus is driven and checked after each frame edge.
module tb_akuma_ai_keygen;

   localparam int          N     = 4;
   localparam logic [63:0] SEEDS = {16'h0005, 16'h0003, 16'h0004, 16'hACE1};
   localparam logic [2:0]  S_IDLE = 3'd0, S_APPROACH = 3'd1, S_RETREAT = 3'd2,
                           S_JUMP = 3'd3, S_CROUCH = 3'd4;

   logic               frame_clk = 1'b0;
   logic               Reset     = 1'b1;
   logic               enable    [N];
   logic signed [31:0] XDist     [N];
   logic [9:0]         AkumaX    [N];
   logic               hit_taken [N];
   logic [7:0]         kc0 [N];
   logic [7:0]         kc1 [N];
   logic [7:0]         kc2 [N];
   logic [7:0]         kc3 [N];
   logic [2:0]         sdbg [N];

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          d;
      logic [34:0] vec;
      string       tag;
   } exp_t;
   exp_t sb[$];

   always #5 frame_clk = ~frame_clk;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         akuma_ai_keygen #(.LFSR_SEED(SEEDS[gi*16 +: 16])) dut (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .enable    (enable[gi]),
            .XDist     (XDist[gi]),
            .AkumaX    (AkumaX[gi]),
            .hit_taken (hit_taken[gi]),
            .keycode_0 (kc0[gi]),
            .keycode_1 (kc1[gi]),
            .keycode_2 (kc2[gi]),
            .keycode_3 (kc3[gi]),
            .state_dbg (sdbg[gi])
         );
      end
   endgenerate

   // Expected {state_dbg, keycode_0..3} for a given behaviour.
   function automatic logic [34:0] vec_of(input logic [2:0] st);
      logic [7:0] a;
      logic [7:0] b;
      a = 8'h00;
      b = 8'h00;
      case (st)
         S_APPROACH: a = 8'h0d;
         S_RETREAT:  a = 8'h0f;
         S_JUMP:     b = 8'h0c;
         S_CROUCH:   b = 8'h0e;
         default:    ;
      endcase
      return {st, a, b, 16'h0000};
   endfunction

   function automatic logic [34:0] obs(input int d);
      return {sdbg[d], kc0[d], kc1[d], kc2[d], kc3[d]};
   endfunction

   function automatic logic [15:0] lfsr_after(input logic [15:0] seed, input int n);
      logic [15:0] v;
      v = seed;
      for (int i = 0; i < n; i++)
         v = (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
      return v;
   endfunction

   function automatic logic [2:0] far_dec(input logic [15:0] lf);
      return (lf[1:0] == 2'd3) ? S_JUMP : S_APPROACH;
   endfunction

   task automatic check(input string tag, input logic [34:0] o, input logic [34:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic push(input int d, input logic [2:0] st, input string tag);
      exp_t e;
      e.d   = d;
      e.vec = vec_of(st);
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge frame_clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.d), e.vec);
         $display("dut%0d %s: state=%0d kc0=%h kc1=%h", e.d, e.tag, sdbg[e.d], kc0[e.d], kc1[e.d]);
      end
      @(negedge frame_clk);
   endtask

   task automatic reset_all();
      Reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         enable[i]    = 1'b0;
         hit_taken[i] = 1'b0;
      end
      @(negedge frame_clk);
      Reset = 1'b0;
   endtask

   task automatic first_edge(input int d, input int xd, input int ax,
                             input logic [2:0] st, input string tag);
      reset_all();
      enable[d] = 1'b1;
      XDist[d]  = xd;
      AkumaX[d] = 10'(ax);
      push(d, st, tag);
      tick();
      enable[d] = 1'b0;
   endtask

   initial begin
      logic [15:0] lf;
      for (int i = 0; i < N; i++) begin
         enable[i]    = 1'b0;
         XDist[i]     = 0;
         AkumaX[i]    = 10'd100;
         hit_taken[i] = 1'b0;
      end
      @(negedge frame_clk);

      // Held in reset: idle outputs, seed held.
      for (int i = 0; i < 5; i++) begin
         push(0, S_IDLE, "rst_hold");
         tick();
         check("rst_lfsr", {19'd0, g_dut[0].dut.lfsr_reg}, {19'd0, 16'hACE1});
      end
      Reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push(0, S_IDLE, "disabled_idle");
         tick();
      end

      // Long range with default seed: 16 frames of approach, then a new decision.
      reset_all();
      enable[0] = 1'b1;
      XDist[0]  = 400;
      for (int i = 0; i < 16; i++) begin
         push(0, S_APPROACH, "far_approach");
         tick();
      end
      lf = lfsr_after(16'hACE1, 16);
      push(0, far_dec(lf), "far_redecide");
      tick();

      // Hit during approach, then a second hit on crouch frame 4.
      hit_taken[0] = 1'b1;
      push(0, S_CROUCH, "hit_crouch");
      tick();
      hit_taken[0] = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push(0, S_CROUCH, "crouch_hold");
         tick();
      end
      hit_taken[0] = 1'b1;
      push(0, S_CROUCH, "crouch_rehit");
      tick();
      hit_taken[0] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         push(0, S_CROUCH, "crouch_extended");
         tick();
      end
      lf = lfsr_after(16'hACE1, 28);
      push(0, far_dec(lf), "crouch_done");
      tick();

      // Disable mid-approach, re-enable, then async reset between edges.
      reset_all();
      enable[0] = 1'b1;
      XDist[0]  = 400;
      push(0, S_APPROACH, "mid_approach");
      tick();
      push(0, S_APPROACH, "mid_approach");
      tick();
      enable[0] = 1'b0;
      push(0, S_IDLE, "disable_idle");
      tick();
      enable[0] = 1'b1;
      lf = lfsr_after(16'hACE1, 3);
      push(0, far_dec(lf), "reenable_decide");
      tick();
      push(0, far_dec(lf), "reenable_hold");
      tick();
      #2;
      Reset = 1'b1;
      #1;
      check("async_reset_out", obs(0), vec_of(S_IDLE));
      check("async_reset_lfsr", {19'd0, g_dut[0].dut.lfsr_reg}, {19'd0, 16'hACE1});
      @(negedge frame_clk);
      Reset = 1'b0;
      enable[0] = 1'b0;

      // Seed 0004 (rnd 0): range boundaries and the right-edge retreat guard.
      first_edge(1, 100, 400, S_RETREAT,  "close_retreat");
      first_edge(1, 100, 510, S_IDLE,     "retreat_at_bound");
      first_edge(1, 100, 509, S_RETREAT,  "retreat_below_bound");
      first_edge(1, 140, 100, S_RETREAT,  "near_inclusive");
      first_edge(1, 141, 100, S_APPROACH, "mid_just_above_near");
      first_edge(1, -50, 100, S_RETREAT,  "negative_xdist");

      // Seed 0005 (rnd 1): far boundary.
      first_edge(3, 299, 100, S_RETREAT,  "mid_just_below_far");
      first_edge(3, 300, 100, S_APPROACH, "far_inclusive");
      first_edge(3, 140, 100, S_JUMP,     "close_jump");

      // Seed 0003 (rnd 3): near boundary, then full jump sequence.
      first_edge(2, 140, 100, S_IDLE, "near_rnd3_idle");
      first_edge(2, 141, 100, S_JUMP, "mid_rnd3_jump");
      reset_all();
      enable[2] = 1'b1;
      XDist[2]  = 400;
      push(2, S_JUMP, "jump_start");
      tick();
      hit_taken[2] = 1'b1;
      push(2, S_JUMP, "jump_hit_ignored");
      tick();
      hit_taken[2] = 1'b0;
      for (int i = 0; i < 16; i++) begin
         push(2, S_IDLE, "jump_landed_idle");
         tick();
      end
      lf = lfsr_after(16'h0003, 18);
      push(2, far_dec(lf), "post_jump_decide");
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
